// File: rtl/rram_command_sequencer.sv
// RRAM command sequencer: synchronises host strobes, decodes the latched command and
// drives timed READ / SET / RESET pulses onto the array with ready/busy reporting.
module rram_command_sequencer #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned READ_CYCLES    = 4,
    parameter int unsigned SET_CYCLES     = 10,
    parameter int unsigned RESET_CYCLES   = 12,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        command,
    input  logic              command_register_ready,
    input  logic [ADDR_W-1:0] address,
    input  logic              address_ready,
    output logic [ADDR_W-1:0] array_addr,
    output logic              read_en,
    output logic              set_en,
    output logic              reset_en,
    output logic              ready_busy_n,
    output logic              status_fail
);

    localparam int unsigned MaxA   = (READ_CYCLES > SET_CYCLES) ? READ_CYCLES : SET_CYCLES;
    localparam int unsigned MaxB   = (RESET_CYCLES > RECOVER_CYCLES) ? RESET_CYCLES
                                                                      : RECOVER_CYCLES;
    localparam int unsigned MaxCyc = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [3:0] CmdRead  = 4'b0001;
    localparam logic [3:0] CmdSet   = 4'b0010;
    localparam logic [3:0] CmdReset = 4'b0011;
    localparam logic [3:0] CmdSoft  = 4'b1111;

    typedef enum logic [1:0] {StIdle, StWaitAddr, StExecute, StRecover} state_e;
    typedef enum logic [1:0] {OpRead, OpSet, OpReset} op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d, set_q, set_d, reset_q, reset_d;
    logic              rb_q, rb_d, fail_q, fail_d;
    logic [2:0]        cmd_sync_q, cmd_sync_d, addr_sync_q, addr_sync_d;
    logic              cmd_stb, addr_stb;

    // Two metastability flops plus a delay flop; strobe marks the rising edge only.
    assign cmd_sync_d  = {cmd_sync_q[1:0], command_register_ready};
    assign addr_sync_d = {addr_sync_q[1:0], address_ready};
    assign cmd_stb     = cmd_sync_q[1] & ~cmd_sync_q[2];
    assign addr_stb    = addr_sync_q[1] & ~addr_sync_q[2];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        read_d  = read_q;
        set_d   = set_q;
        reset_d = reset_q;
        rb_d    = rb_q;
        fail_d  = fail_q;
        if (state_q != StIdle && cmd_stb && command == CmdSoft) begin
            // Abort: array_addr deliberately left untouched.
            state_d = StIdle;
            read_d  = 1'b0;
            set_d   = 1'b0;
            reset_d = 1'b0;
            rb_d    = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_stb) begin
                        case (command)
                            CmdRead, CmdSet, CmdReset: begin
                                op_d    = (command == CmdRead) ? OpRead :
                                          (command == CmdSet)  ? OpSet  : OpReset;
                                fail_d  = 1'b0;
                                rb_d    = 1'b0;
                                state_d = StWaitAddr;
                            end
                            CmdSoft: fail_d = 1'b0;
                            default: fail_d = 1'b1;
                        endcase
                    end
                end
                StWaitAddr: begin
                    if (addr_stb) begin
                        addr_d  = address;
                        state_d = StExecute;
                        case (op_q)
                            OpRead: begin
                                cnt_d  = CntW'(READ_CYCLES - 1);
                                read_d = 1'b1;
                            end
                            OpSet: begin
                                cnt_d = CntW'(SET_CYCLES - 1);
                                set_d = 1'b1;
                            end
                            default: begin
                                cnt_d   = CntW'(RESET_CYCLES - 1);
                                reset_d = 1'b1;
                            end
                        endcase
                    end
                end
                StExecute: begin
                    if (cnt_q == '0) begin
                        read_d  = 1'b0;
                        set_d   = 1'b0;
                        reset_d = 1'b0;
                        cnt_d   = CntW'(RECOVER_CYCLES - 1);
                        state_d = StRecover;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StRecover: begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                        rb_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= OpRead;
            cnt_q       <= '0;
            addr_q      <= '0;
            read_q      <= 1'b0;
            set_q       <= 1'b0;
            reset_q     <= 1'b0;
            rb_q        <= 1'b1;
            fail_q      <= 1'b0;
            cmd_sync_q  <= '0;
            addr_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            set_q       <= set_d;
            reset_q     <= reset_d;
            rb_q        <= rb_d;
            fail_q      <= fail_d;
            cmd_sync_q  <= cmd_sync_d;
            addr_sync_q <= addr_sync_d;
        end
    end

    assign array_addr   = addr_q;
    assign read_en      = read_q;
    assign set_en       = set_q;
    assign reset_en     = reset_q;
    assign ready_busy_n = rb_q;
    assign status_fail  = fail_q;

endmodule

// File: doc/rram_command_sequencer.md
Name: rram_command_sequencer

Overview:
- Sits directly downstream of the command register and the address register.
- Synchronises the asynchronous command_register_ready and address_ready strobes into the array clock domain, then decodes the latched 4-bit command.
- Runs a timed READ / SET / RESET pulse sequence on the RRAM array and reports ready/busy back to the host interface.

Parameters:
- ADDR_W, 8, width of the array address.
- READ_CYCLES, 4, clocks read_en is held high.
- SET_CYCLES, 10, clocks set_en is held high.
- RESET_CYCLES, 12, clocks reset_en is held high.
- RECOVER_CYCLES, 2, idle clocks after any pulse before returning to IDLE.

Ports:
- clk  input  1  array clock.
- rst_n  input  1  asynchronous active-low reset.
- command  input  4  latched command from the command register.
- command_register_ready  input  1  level, asynchronous to clk; high means command is valid.
- address  input  ADDR_W  latched address from the address register.
- address_ready  input  1  level, asynchronous to clk; high means address is valid.
- array_addr  output  ADDR_W  address driven to the array decoders.
- read_en  output  1  read pulse.
- set_en  output  1  SET (program) pulse.
- reset_en  output  1  RESET (erase) pulse.
- ready_busy_n  output  1  1 = ready, 0 = busy.
- status_fail  output  1  last command was invalid.

Behaviour:
- One clock domain. Reset is asynchronous and active-low: clk and rst_n; polarity and synchronicity are fixed.
- Reset values: array_addr=0, read_en=set_en=reset_en=0, ready_busy_n=1, status_fail=0, FSM=IDLE, counter=0, all sync flops=0.
- Synchronisers: command_register_ready and address_ready each pass through 2 flops plus a third delay flop.
  - strobe = sync2 & ~sync3.
  - The FSM acts on the 3rd rising clk edge after the input goes high.
  - Exactly one strobe per low-to-high transition; holding the input high does not retrigger.
- command and address are sampled on the edge the FSM consumes their strobe. They must be stable by then, which the host timing guarantees.
- Command encodings:
  - 4'b0001 READ
  - 4'b0010 SET
  - 4'b0011 RESET
  - 4'b1111 SOFT_RESET
  - all other codes invalid.
- FSM states: IDLE, WAIT_ADDR, EXECUTE, RECOVER.
- IDLE, on cmd strobe:
  - READ/SET/RESET: store op, clear status_fail, go to WAIT_ADDR, ready_busy_n<=0.
  - SOFT_RESET: stay IDLE, clear status_fail.
  - invalid: stay IDLE, status_fail<=1.
- WAIT_ADDR, on address strobe:
  - array_addr<=address.
  - counter<=op cycle count minus 1.
  - matching enable<=1.
  - go to EXECUTE.
- EXECUTE:
  - Exactly one enable is high for exactly READ_CYCLES, SET_CYCLES or RESET_CYCLES clocks.
  - On the final count, enable<=0, counter<=RECOVER_CYCLES-1, go to RECOVER.
- RECOVER: all enables 0. On the final count go to IDLE and set ready_busy_n<=1.
- Enables are mutually exclusive and registered, so no glitches.
- array_addr holds its value until the next address capture.
- Busy-state command strobes:
  - SOFT_RESET in WAIT_ADDR, EXECUTE or RECOVER aborts on that edge: all enables 0, FSM=IDLE, ready_busy_n=1, array_addr unchanged.
  - Any other command strobe while busy is ignored, with no status change.
- An address strobe outside WAIT_ADDR is ignored.
- If the cmd strobe and address strobe fall on the same edge in IDLE, the command is taken and the address is ignored; the host must re-strobe the address.
- If rst_n is asserted mid-pulse, the enable drops immediately (asynchronously) and all outputs take their reset values.
- Each *_CYCLES parameter must be ≥1; a value of 1 gives a single-clock pulse.

Test Plan:
- Reset, then command=4'b1111 with command_register_ready rising → state stays IDLE, ready_busy_n stays 1, status_fail=0, no enable ever high.
- READ: command=4'b0001 strobe, then address=8'h5A strobe → ready_busy_n falls on the 3rd edge after cmd; read_en high exactly 4 clocks with array_addr=8'h5A; ready_busy_n returns to 1 exactly 2 clocks after read_en falls.
- SET then RESET, back to back:
  - SET at address 8'h01 → set_en high exactly 10 clocks.
  - RESET at address 8'hFF, issued after ready → reset_en high exactly 12 clocks.
  - set_en and reset_en are never high together.
- Invalid command 4'b0111 → status_fail=1, ready_busy_n stays 1; a following valid READ clears status_fail on its accept edge.
- SET in progress, 4'b1111 strobe in the 5th pulse clock → set_en=0 and ready_busy_n=1 on the abort edge; a 4'b0001 strobe while busy in another run is ignored.
- rst_n pulled low mid-RESET pulse → reset_en and all other outputs drop to reset values without waiting for clk; after release the block accepts a new READ normally.
